// File: rtl/relay_pkg.sv
// relay_pkg: shared types and constants for the latching relay sequencer.
//   state_t        FSM encoding used by relay_sched
//   SEL_324R/50R   relay position codes carried on req_sel / sel_out / relay_state
//   DEF_*_CYC      default pulse and settling-guard lengths at 22.1184 MHz
package relay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam logic SEL_324R = 1'b0;
    localparam logic SEL_50R  = 1'b1;

    // 2^15-count driver pulse, plus ~100 us of contact settling.
    localparam int DEF_PULSE_CYC = 32768;
    localparam int DEF_GUARD_CYC = 2212;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req          in  NCH  request vector
//   rr           in  RW   priority pointer; search starts at this index
//   grant        out NCH  one-hot grant
//   grant_idx    out RW   index of the granted requester
//   grant_valid  out 1    at least one request is present
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int RW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [RW-1:0]  rr,
    output logic [NCH-1:0] grant,
    output logic [RW-1:0]  grant_idx,
    output logic           grant_valid
);

    int            c;
    logic [RW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        c           = 0;
        idx         = '0;
        // Walk NCH positions starting at rr, wrapping; first hit wins.
        for (int i = 0; i < NCH; i++) begin
            c = int'(rr) + i;
            if (c >= NCH) c = c - NCH;
            idx = RW'(c);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/relay_sched.sv
// relay_sched: arbitrates relay-position requests and sequences one relay
// pulse at a time, tracking the known position of each latching relay.
//   clk, reset         system clock, synchronous active-high reset
//   req/req_sel/req_force  per-channel request, position, force-pulse
//   ack                one-cycle completion strobe to the served channel
//   busy               FSM not idle
//   gen_pulse/sel_out  start strobe and position select to each relay driver
//   relay_state/state_valid  last driven position and whether it is known
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; grants and decides skip vs pulse
// ST_FIRE | gen_pulse strobe out, sel_out already loaded; load counter
// ST_WAIT | pulse + guard down-count; sel_out frozen
// ST_ACK  | ack strobe out; advance round-robin pointer
module relay_sched
    import relay_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GUARD_CYC = DEF_GUARD_CYC
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] req_sel,
    input  logic [NCH-1:0] req_force,
    output logic [NCH-1:0] ack,
    output logic           busy,
    output logic [NCH-1:0] gen_pulse,
    output logic [NCH-1:0] sel_out,
    output logic [NCH-1:0] relay_state,
    output logic [NCH-1:0] state_valid
);

    localparam int RW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(PULSE_CYC + GUARD_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC + GUARD_CYC - 1);
    localparam logic [RW-1:0]    LAST_CH  = RW'(NCH - 1);

    state_t           state;
    logic [RW-1:0]    rr;
    logic [RW-1:0]    g_idx;
    logic [NCH-1:0]   g_oh;
    logic             g_sel;
    logic             pulsed;
    logic [CNT_W-1:0] cnt;

    logic [NCH-1:0]   arb_grant;
    logic [RW-1:0]    arb_idx;
    logic             arb_valid;

    rr_arbiter #(.NCH(NCH), .RW(RW)) u_arb (
        .req         (req),
        .rr          (rr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr          <= '0;
            g_idx       <= '0;
            g_oh        <= '0;
            g_sel       <= SEL_324R;
            pulsed      <= 1'b0;
            cnt         <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            gen_pulse   <= '0;
            sel_out     <= {NCH{SEL_324R}};
            relay_state <= {NCH{SEL_324R}};
            state_valid <= '0;
        end else begin
            ack       <= '0;
            gen_pulse <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        g_idx <= arb_idx;
                        g_oh  <= arb_grant;
                        g_sel <= req_sel[arb_idx];
                        busy  <= 1'b1;
                        // Latching relay already in the requested position: no pulse needed.
                        if (state_valid[arb_idx] && (relay_state[arb_idx] == req_sel[arb_idx])
                                && !req_force[arb_idx]) begin
                            pulsed <= 1'b0;
                            ack    <= arb_grant;
                            state  <= ST_ACK;
                        end else begin
                            pulsed           <= 1'b1;
                            sel_out[arb_idx] <= req_sel[arb_idx];
                            gen_pulse        <= arb_grant;
                            state            <= ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    cnt   <= CNT_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        ack   <= g_oh;
                        state <= ST_ACK;
                        // Position becomes known together with the completion strobe.
                        relay_state[g_idx] <= g_sel;
                        state_valid[g_idx] <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    rr    <= (g_idx == LAST_CH) ? '0 : g_idx + 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relay_sched.sv
module tb_relay_sched;

    localparam int NCH    = 4;
    localparam int PC     = 8;
    localparam int GC     = 4;
    localparam int OP_LAT = PC + GC + 2;   // grant at T -> ack at T+14

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] req = '0;
    logic [NCH-1:0] req_sel = '0;
    logic [NCH-1:0] req_force = '0;
    logic [NCH-1:0] ack;
    logic           busy;
    logic [NCH-1:0] gen_pulse;
    logic [NCH-1:0] sel_out;
    logic [NCH-1:0] relay_state;
    logic [NCH-1:0] state_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    relay_sched #(.NCH(NCH), .PULSE_CYC(PC), .GUARD_CYC(GC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_sel     (req_sel),
        .req_force   (req_force),
        .ack         (ack),
        .busy        (busy),
        .gen_pulse   (gen_pulse),
        .sel_out     (sel_out),
        .relay_state (relay_state),
        .state_valid (state_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advances from grant cycle T until ack appears (bounded); reports the
    // ack cycle offset (-1 on timeout) and what gen_pulse did meanwhile.
    task automatic wait_ack(output int ack_cyc, output int pulse_cnt, output int pulse_at,
                            output logic [NCH-1:0] ack_mask);
        int n;
        n = 0; ack_cyc = -1; pulse_cnt = 0; pulse_at = -1; ack_mask = '0;
        while (n < 60) begin
            tick();
            n++;
            if (gen_pulse != '0) begin
                pulse_cnt++;
                pulse_at = n;
            end
            if (ack != '0) begin
                ack_cyc  = n;
                ack_mask = ack;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({ack, busy, gen_pulse, sel_out, relay_state, state_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b busy=%b gp=%b sel=%b rs=%b sv=%b want all zero",
                     ack, busy, gen_pulse, sel_out, relay_state, state_valid);
        end
    endtask

    task automatic test_single;
        bit sel_ok;
        int extra;
        sel_ok = 1'b1; extra = 0;
        req[1] = 1'b1; req_sel[1] = 1'b1;
        tick();
        total++;
        if (gen_pulse !== 4'b0010 || sel_out[1] !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_fire got gp=%b sel1=%b busy=%b want gp=0010 sel1=1 busy=1",
                     gen_pulse, sel_out[1], busy);
        end
        for (int k = 2; k < OP_LAT; k++) begin
            tick();
            if (sel_out[1] !== 1'b1 || busy !== 1'b1) sel_ok = 1'b0;
            if (gen_pulse !== '0 || ack !== '0) extra++;
        end
        total++;
        if (!sel_ok) begin
            bad++;
            $display("FAIL single_sel_frozen got sel_out=%b want bit1 held 1", sel_out);
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL single_wait_quiet got %0d stray strobe cycles want 0", extra);
        end
        tick();
        total++;
        if (ack !== 4'b0010) begin
            bad++;
            $display("FAIL single_ack_t14 got ack=%b want 0010", ack);
        end
        req[1] = 1'b0;
        tick();
        total++;
        if (relay_state[1] !== 1'b1 || state_valid !== 4'b0010 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_state got rs=%b sv=%b busy=%b want rs[1]=1 sv=0010 busy=0",
                     relay_state, state_valid, busy);
        end
    endtask

    task automatic test_skip;
        int ac, pc, pa;
        logic [NCH-1:0] am;
        req[1] = 1'b1; req_sel[1] = 1'b1;
        wait_ack(ac, pc, pa, am);
        total++;
        if (ac != 1 || pc != 0 || am !== 4'b0010) begin
            bad++;
            $display("FAIL skip_ack got cyc=%0d pulses=%0d ack=%b want cyc=1 pulses=0 ack=0010",
                     ac, pc, am);
        end
        req[1] = 1'b0;
        tick();
        req[1] = 1'b1; req_force[1] = 1'b1;
        wait_ack(ac, pc, pa, am);
        total++;
        if (ac != OP_LAT || pc != 1 || pa != 1 || am !== 4'b0010) begin
            bad++;
            $display("FAIL force_pulse got cyc=%0d pulses=%0d at=%0d ack=%b want cyc=14 pulses=1 at=1 ack=0010",
                     ac, pc, pa, am);
        end
        req[1] = 1'b0; req_force[1] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        int ac, pc, pa;
        logic [NCH-1:0] am;
        logic [NCH-1:0] order_ch [6];
        order_ch = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111; req_sel = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                req = 4'b1001; req_sel = 4'b1000;
            end
            wait_ack(ac, pc, pa, am);
            total++;
            if (am !== order_ch[i] || ac != OP_LAT || busy !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant%0d got ack=%b cyc=%0d busy=%b want ack=%b cyc=14 busy=1",
                         i, am, ac, busy, order_ch[i]);
            end
            req = req & ~order_ch[i];
            tick();
        end
        total++;
        if (relay_state !== 4'b1100 || state_valid !== 4'b1111) begin
            bad++;
            $display("FAIL rr_states got rs=%b sv=%b want rs=1100 sv=1111", relay_state, state_valid);
        end
        req_sel = '0;
    endtask

    task automatic test_sel_during_wait;
        bit sel_ok;
        sel_ok = 1'b1;
        req[2] = 1'b1; req_sel[2] = 1'b0;
        for (int k = 1; k < OP_LAT; k++) begin
            tick();
            if (sel_out[2] !== 1'b0) sel_ok = 1'b0;
            if (k == 5) req_sel[2] = 1'b1;
            if (k == 6) req[2] = 1'b0;
        end
        total++;
        if (!sel_ok) begin
            bad++;
            $display("FAIL selchg_frozen got sel_out=%b want bit2 held 0", sel_out);
        end
        tick();
        total++;
        if (ack !== 4'b0100) begin
            bad++;
            $display("FAIL selchg_ack_after_drop got ack=%b want 0100", ack);
        end
        tick();
        total++;
        if (relay_state[2] !== 1'b0 || sel_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL selchg_state got rs=%b sel=%b want bit2 of both 0", relay_state, sel_out);
        end
        req_sel = '0;
    endtask

    task automatic test_reset_mid_wait;
        int ac, pc, pa, acks;
        logic [NCH-1:0] am;
        acks = 0;
        req[3] = 1'b1; req_sel[3] = 1'b1; req_force[3] = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        reset = 1'b1; req = '0; req_force = '0;
        tick();
        reset = 1'b0;
        total++;
        if ({ack, busy, gen_pulse, sel_out, state_valid} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got ack=%b busy=%b gp=%b sel=%b sv=%b want all zero",
                     ack, busy, gen_pulse, sel_out, state_valid);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack !== '0 || busy !== 1'b0) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL midreset_no_ack got %0d active cycles want 0", acks);
        end
        req[3] = 1'b1; req_sel[3] = 1'b1;
        wait_ack(ac, pc, pa, am);
        total++;
        if (ac != OP_LAT || pc != 1 || am !== 4'b1000) begin
            bad++;
            $display("FAIL midreset_repulse got cyc=%0d pulses=%0d ack=%b want cyc=14 pulses=1 ack=1000",
                     ac, pc, am);
        end
        req = '0;
        tick();
        total++;
        if (relay_state !== 4'b1000 || state_valid !== 4'b1000) begin
            bad++;
            $display("FAIL midreset_state got rs=%b sv=%b want rs=1000 sv=1000", relay_state, state_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skip();
        test_round_robin();
        test_sel_during_wait();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relay_sched.md
# relay_sched

Sequencer and arbiter for the latching impedance relays. Up to NCH requesters (host command decoder, auto-range logic) each ask for a relay channel to be set to the 324 Ω (sel=0) or 50 Ω (sel=1) position. The block grants one channel at a time and fires that channel's relay pulse driver via `gen_pulse`/`sel`. It holds `sel` stable until the pulse plus a settling guard has elapsed, then tracks the resulting relay state. Because the relays are latching, requests for a position already known to be set are acknowledged without pulsing.

## Interface
- NCH, 4, number of relay channels / requesters
- PULSE_CYC, 32768, cycles the relay driver pulse can last after `gen_pulse` (covers 2^15-count driver at 22.1184 MHz)
- GUARD_CYC, 2212, extra settling cycles after pulse (~100 µs)
- clk  in  1  system clock (22.1184 MHz)
- reset  in  1  synchronous, active-high reset
- req  in  NCH  per-channel request level; held until `ack`
- req_sel  in  NCH  requested position per channel; 0=324 Ω, 1=50 Ω; sampled at grant
- req_force  in  NCH  pulse even if position already known
- ack  out  NCH  one-cycle completion strobe to the granted channel
- busy  out  1  high whenever FSM not in IDLE
- gen_pulse  out  NCH  one-cycle start strobe to that channel's relay driver
- sel_out  out  NCH  position select to each relay driver
- relay_state  out  NCH  last position driven per channel
- state_valid  out  NCH  relay_state known (cleared by reset)

## Operation
- FSM states: IDLE, FIRE, WAIT, ACK.
- IDLE, transition rule: if any `req` is high, a round-robin grant is made starting at pointer `rr`; the block latches grant index g and `req_sel[g]`.
  - Skip condition: `state_valid[g]` && `relay_state[g]==req_sel[g]` && !`req_force[g]`. When it holds → ACK.
  - Otherwise → FIRE, and `sel_out[g]` is loaded with the latched sel in the same edge.
- FIRE: `gen_pulse[g]`=1 for exactly this cycle. Counter is loaded with PULSE_CYC+GUARD_CYC-1. → WAIT.
- WAIT: counter decrements each cycle; at 0 → ACK. `sel_out` is frozen throughout, because the driver muxes the pulse by sel combinationally.
- ACK:
  - `ack[g]`=1 for one cycle.
  - If pulsed: `relay_state[g]`←sel, `state_valid[g]`←1.
  - `rr`←g+1, wrapping NCH-1→0. → IDLE.
- `sel_out` bits retain value after ACK; only the FIRE load of the granted channel changes them.
- `req` dropped before grant: the request is ignored. `req` still high after `ack`: treated as a new request and arbitrated next IDLE cycle. `req` dropped during WAIT: the operation completes anyway and `ack` is still issued.
- `req_sel` changes after grant have no effect on the current operation.
- Simultaneous requests: the lowest index at or above `rr` wins; the others wait. No starvation: any requester is served within NCH grants.
- Only one channel is pulsed at a time, which limits coil supply current.

## Timing
- Reset values: FSM=IDLE, `rr`=0, `ack`=0, `gen_pulse`=0, `sel_out`=0, `relay_state`=0, `state_valid`=0, `busy`=0.
- Reset mid-operation: FSM returns to IDLE next edge with no ack. `state_valid` is cleared, since the position is unknown. The relay driver shares `reset`, so its pulse also stops.
- Grant in IDLE at cycle T, pulsed path:
  - `gen_pulse` at T+1.
  - WAIT occupies T+2 … T+1+PULSE_CYC+GUARD_CYC.
  - `ack` at T+2+PULSE_CYC+GUARD_CYC.
  - Next grant possible at T+3+PULSE_CYC+GUARD_CYC.
- Skip path: `ack` at T+1; next grant at T+2.
- `busy` is high from T+1 through the ACK cycle inclusive.
- Counter width: $clog2(PULSE_CYC+GUARD_CYC). Unsigned arithmetic, no wrap below 0.
- All outputs are registered.

## Structure
- Package `relay_pkg`:
  - FSM state enum (IDLE, FIRE, WAIT, ACK).
  - Constants SEL_324R=0 and SEL_50R=1.
  - Default PULSE_CYC and GUARD_CYC.
- Sub-module `rr_arbiter` (NCH-wide, combinational grant from req and rr pointer; outputs one-hot grant, index, valid). The FSM and counter stay in `relay_sched`.
- Instantiated above NCH copies of the relay pulse driver; `gen_pulse[i]`/`sel_out[i]` connect to driver i.

## Test plan
Bench uses NCH=4, PULSE_CYC=8, GUARD_CYC=4.
- **Single pulsed request:** after reset, req[1]=1, req_sel[1]=1 → gen_pulse[1] one cycle at T+1, sel_out[1]=1 frozen through WAIT, ack[1] at T+14, relay_state[1]=1, state_valid[1]=1.
- **Skip path:** repeat req[1] with sel=1 → ack[1] at T+1, no gen_pulse. Same request with req_force[1]=1 → pulses again and acks at T+14.
- **Round robin:** req=4'b1111 all held until each one's own ack → grant order 0,1,2,3. Then req=4'b1001 with rr=0 → 0 then 3. Pointer wraps after channel 3.
- **Sel change during WAIT:** req_sel[2] toggled during WAIT → sel_out[2] unchanged, relay_state[2]=originally latched value.
- **Reset mid-WAIT:** reset=1 for one cycle during WAIT → no ack, busy=0, gen_pulse=0, sel_out=0, state_valid=0 next cycle. A subsequent same-position request pulses because the state is unknown.
